// File: rtl/gpu_shader_pipe_if.sv
// ----------------------------------------------------------------------------
// gpu_shader_pipe_if
// Bundles the instruction-side and result-side handshakes of the shader ALU
// pipe.
//   master : the dispatcher/writeback side. It drives the instruction fields
//            and out_ready.
//   slave  : the pipe itself. It drives in_ready, the result fields and
//            inflight.
// Signals:
//   in_valid/in_ready      instruction handshake
//   in_opcode, in_is_vector, in_sat, in_mask, in_tag, in_a/in_b/in_c
//                          instruction fields, sampled on accept
//   out_valid/out_ready    result handshake
//   out_result, out_tag, out_err
//                          result fields
//   inflight               number of occupied stages
// ----------------------------------------------------------------------------
interface gpu_shader_pipe_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned TAG_W    = 4
);
    localparam int unsigned LW    = WIDTH * LANES;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] in_opcode;
    logic                in_is_vector;
    logic                in_sat;
    logic [LANES-1:0]    in_mask;
    logic [TAG_W-1:0]    in_tag;
    logic [LW-1:0]       in_a;
    logic [LW-1:0]       in_b;
    logic [LW-1:0]       in_c;
    logic                out_valid;
    logic                out_ready;
    logic [LW-1:0]       out_result;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;
    logic [CNT_W-1:0]    inflight;

    modport master (
        output in_valid, in_opcode, in_is_vector, in_sat, in_mask, in_tag,
               in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err, inflight
    );

    modport slave (
        input  in_valid, in_opcode, in_is_vector, in_sat, in_mask, in_tag,
               in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err, inflight
    );
endinterface

// File: rtl/gpu_shader_pipe.sv
// ----------------------------------------------------------------------------
// gpu_shader_pipe
// This is a DEPTH-stage elastic SIMD ALU pipeline that accepts one
// instruction per cycle. The whole operation is evaluated when an instruction
// is accepted, and stage 0 captures the result, tag and error flag. The later
// stages only carry that payload forward. A stage advances when it is empty
// or when the stage ahead of it advances, so bubbles collapse while the
// output is stalled.
// Ports:
//   clk   : clock, active on the rising edge
//   rst_n : asynchronous active-low reset. It discards every in-flight entry.
//   bus   : gpu_shader_pipe_if.slave, which carries the instruction and
//           result handshakes and the inflight count
// ----------------------------------------------------------------------------
module gpu_shader_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned TAG_W    = 4
) (
    input logic              clk,
    input logic              rst_n,
    gpu_shader_pipe_if.slave bus
);
    localparam int unsigned LW    = WIDTH * LANES;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_MAC = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_MIN = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_MAX = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(8);

    // Stage storage. Index DEPTH-1 is the output stage.
    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_err;
    logic [LW-1:0]    stg_result [DEPTH];
    logic [TAG_W-1:0] stg_tag    [DEPTH];
    logic [CNT_W-1:0] inflight_q;

    logic [DEPTH-1:0] adv;
    logic             tail_full;
    logic             accept;
    logic             out_fire;
    logic             illegal;
    logic [LW-1:0]    new_result;

    // s is a WIDTH+1 bit signed sum. An overflow shows up as the top two
    // bits disagreeing, and the top bit gives the true sign.
    function automatic logic [WIDTH-1:0] sat_or_wrap(input logic [WIDTH:0] s,
                                                     input logic sat);
        if (sat && (s[WIDTH] != s[WIDTH-1])) begin
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] lane_op(input logic [OPCODE_W-1:0] op,
                                                 input logic sat,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        logic [2*WIDTH-1:0] full;
        logic [WIDTH-1:0]   prod;
        logic               lt;
        logic [WIDTH-1:0]   r;
        // The low half of a product is the same for signed and unsigned
        // operands.
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod = full[WIDTH-1:0];
        lt   = $signed(a) < $signed(b);
        case (op)
            OP_ADD:  r = sat_or_wrap({a[WIDTH-1], a} + {b[WIDTH-1], b}, sat);
            OP_SUB:  r = sat_or_wrap({a[WIDTH-1], a} - {b[WIDTH-1], b}, sat);
            OP_MUL:  r = prod;
            OP_MAC:  r = sat_or_wrap({prod[WIDTH-1], prod} + {c[WIDTH-1], c}, sat);
            OP_MIN:  r = lt ? a : b;
            OP_MAX:  r = lt ? b : a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stage k may move when any stage from k to the output is empty, or when
    // the consumer takes the output.
    always_comb begin
        adv       = '0;
        tail_full = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            tail_full = 1'b1;
            for (int j = k; j < DEPTH; j++) begin
                tail_full = tail_full & stg_valid[j];
            end
            adv[k] = bus.out_ready | ~tail_full;
        end
    end

    assign accept   = bus.in_valid & adv[0];
    assign out_fire = stg_valid[DEPTH-1] & bus.out_ready;

    always_comb begin
        illegal    = bus.in_opcode > OP_XOR;
        new_result = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_is_vector ? bus.in_mask[i] : (i == 0)) begin
                new_result[i*WIDTH +: WIDTH] = lane_op(bus.in_opcode, bus.in_sat,
                                                       bus.in_a[i*WIDTH +: WIDTH],
                                                       bus.in_b[i*WIDTH +: WIDTH],
                                                       bus.in_c[i*WIDTH +: WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid  <= '0;
            stg_err    <= '0;
            inflight_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_result[k] <= '0;
                stg_tag[k]    <= '0;
            end
        end else begin
            if (adv[0]) begin
                stg_valid[0] <= accept;
                if (accept) begin
                    stg_result[0] <= new_result;
                    stg_tag[0]    <= bus.in_tag;
                    stg_err[0]    <= illegal;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_result[k] <= stg_result[k-1];
                        stg_tag[k]    <= stg_tag[k-1];
                        stg_err[k]    <= stg_err[k-1];
                    end
                end
            end
            case ({accept, out_fire})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.in_ready   = adv[0];
    assign bus.out_valid  = stg_valid[DEPTH-1];
    assign bus.out_result = stg_result[DEPTH-1];
    assign bus.out_tag    = stg_tag[DEPTH-1];
    assign bus.out_err    = stg_err[DEPTH-1];
    assign bus.inflight   = inflight_q;
endmodule

// File: doc/gpu_shader_pipe.md
Name: gpu_shader_pipe

Overview:
Next-generation shader ALU core. It replaces the single-entry, one-op-at-a-time core with a DEPTH-stage elastic pipeline that accepts one instruction per cycle. New over the previous core:
- per-lane execution mask
- extended opcode set
- signed saturation mode
- transaction tag carried to the result
- illegal-opcode flag
- in-flight counter

It sits between the instruction/operand dispatcher and the result writeback.

Parameters:
- WIDTH, 32, bits per lane.
- LANES, 4, vector lanes; >=1.
- OPCODE_W, 4, opcode field width; >=4.
- DEPTH, 3, pipeline stages from accept to result; >=1.
- TAG_W, 4, tag width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction + operands valid
- in_ready  out  1  pipeline can accept
- in_opcode  in  OPCODE_W  operation
- in_is_vector  in  1  1 = all lanes, 0 = scalar (lane 0 only)
- in_sat  in  1  signed saturation for ADD/SUB/MAC
- in_mask  in  LANES  lane enable; vector mode only
- in_tag  in  TAG_W  transaction tag
- in_a, in_b, in_c  in  WIDTH*LANES  operands; lane i = bits [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  WIDTH*LANES  lane results
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  illegal opcode
- inflight  out  $clog2(DEPTH+1)  count of occupied stages

Behaviour:
- Reset (async, rst_n=0):
  - all stage valids clear.
  - out_valid=0, out_result=0, out_tag=0, out_err=0, inflight=0.
  - in_ready=1 at the first edge after deassert.
- Accept: when in_valid & in_ready at a clk edge. Compute happens at accept; stage 0 captures result, tag and err. Later stages carry these unchanged.
- Elastic advance:
  - Stage DEPTH-1 (the output stage) advances if empty or out_ready=1.
  - Stage k advances if it is empty or stage k+1 advances.
  - in_ready = stage 0 advances. This is combinational from out_ready when the pipe is full.
  - Bubbles collapse: an empty stage accepts from the stage behind it even while the output stalls.
- Latency: with no stall, accept at edge N gives out_valid=1 after edge N+DEPTH-1. Throughput is 1 per cycle.
- Output stability: while out_valid & !out_ready, out_result, out_tag and out_err hold stable.
- inflight: number of valid stages. It changes by +1 on accept only, -1 on output handshake only, and is unchanged when both occur in the same cycle. Its maximum is DEPTH.
- Opcodes (signed two's complement per lane):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 MUL: low WIDTH bits of a*b
  - 3 MAC: low(a*b)+c
  - 4 MIN: signed min(a,b)
  - 5 MAX: signed max(a,b)
  - 6 AND: a&b
  - 7 OR: a|b
  - 8 XOR: a^b
- Saturation:
  - in_sat=1: ADD, SUB and the MAC final add clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - in_sat=0: those results wrap.
  - in_sat is ignored for other opcodes.
  - The MUL/MAC product is always truncated, never saturated.
- Illegal opcode (>8): all lanes = 0, out_err=1. It still occupies a slot and returns its tag.
- Lane rules:
  - Vector: lane i = op result if in_mask[i], else 0.
  - Scalar: lane 0 = op result, lanes 1..LANES-1 = 0, in_mask ignored.
- Simultaneous events: accept and output handshake in the same cycle on a full pipe is legal and loses nothing.
- Input qualification: operands are sampled only on accept; values while !in_valid are don't-care.
- Reset mid-operation: all in-flight instructions are discarded, with no output for them after reset.

Test Plan:
- DEPTH=3, out_ready=1. Back-to-back ADD vector: a lanes=1,2,3,4; b lanes=10,20,30,40; tags 1,2. Required: results 11,22,33,44 tag1 on the cycle after edge N+2, then tag2 the next cycle, inflight peaks at 2.
- Saturation, WIDTH=32. ADD a=0x7FFFFFF0, b=0x20: sat=1 gives 0x7FFFFFFF; sat=0 gives 0x80000010. SUB a=0x80000000, b=1 with sat=1 gives 0x80000000.
- Mask and scalar:
  - Vector MUL, mask=4'b0101, a lanes=3,3,3,3, b lanes=5,5,5,5 gives lanes 15,0,15,0.
  - Scalar MAC 3*4+5 gives lane0=17, others 0.
- Backpressure:
  - Hold out_ready=0 and issue 5 instructions. Required: exactly 3 accepted, in_ready=0, inflight=3, outputs stable.
  - Release out_ready. Required: tags drain in order with no drop or duplicate.
- Opcode 0xF, tag=7. Required: out_err=1, result all 0, out_tag=7. The next legal opcode gives out_err=0.
- Assert rst_n=0 with 2 in flight. Required: out_valid=0, inflight=0 immediately (async). After release, no stale results appear.
